// File: rtl/tlc_pkg.sv
// Shared types and helpers for the traffic-light lamp guard.
package tlc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        RED    = 2'd1,
        YELLOW = 2'd2,
        GREEN  = 2'd3
    } lamp_t;

    localparam logic [1:0] FC_NONE  = 2'd0;
    localparam logic [1:0] FC_MULTI = 2'd1;
    localparam logic [1:0] FC_SEQ   = 2'd2;
    localparam logic [1:0] FC_DARK  = 2'd3;

    // Legal phase successor: RED -> YELLOW -> GREEN -> RED.
    function automatic lamp_t lamp_succ(input lamp_t l);
        lamp_t s;
        s = NONE;
        case (l)
            RED:     s = YELLOW;
            YELLOW:  s = GREEN;
            GREEN:   s = RED;
            default: s = NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tlc_flash_gen.sv
// Flash pattern generator: on for FLASH_HALF cycles, off for FLASH_HALF cycles.
// flash_on is a look-ahead of the counter value taken on the coming edge, so the
// parent can register it into lamp_y on the same edge the counter advances.
module tlc_flash_gen #(
    parameter int unsigned FLASH_HALF = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic restart,
    output logic flash_on
);

    // One extra bit so a full period of 2*FLASH_HALF fits for any legal FLASH_HALF.
    localparam int unsigned FW     = CNT_W + 1;
    localparam int unsigned PERIOD = 2 * FLASH_HALF;

    logic [FW-1:0] flash_cnt;
    logic [FW-1:0] cnt_nxt;

    // Next count: cleared on restart or while idle, wraps at PERIOD-1.
    always_comb begin
        cnt_nxt = '0;
        if (restart || !enable) begin
            cnt_nxt = '0;
        end else if (flash_cnt == FW'(PERIOD - 1)) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = flash_cnt + FW'(1);
        end
    end

    assign flash_on = (cnt_nxt < FW'(FLASH_HALF));

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flash_cnt <= '0;
        end else begin
            flash_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/tlc_lamp_guard.sv
// Lamp guard: passes legal controller lamp patterns to the lamps with one cycle
// of latency, and on conflict / bad order / prolonged dark latches a fault code
// and flashes yellow until fault_clr or reset.
module tlc_lamp_guard
    import tlc_pkg::*;
#(
    parameter int unsigned FLASH_HALF = 4,
    parameter int unsigned DARK_MAX   = 8,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       r,
    input  logic       g,
    input  logic       y,
    input  logic       fault_clr,
    output logic       lamp_r,
    output logic       lamp_g,
    output logic       lamp_y,
    output logic       fault,
    output logic [1:0] fault_code
);

    state_t           state,     state_nxt;
    lamp_t            last_lamp, last_nxt;
    logic [CNT_W-1:0] dark_cnt,  dark_nxt;
    logic             lamp_r_nxt, lamp_g_nxt, lamp_y_nxt, fault_nxt;
    logic [1:0]       code_nxt;
    logic             enter_c;
    logic [1:0]       enter_code_c;
    logic             multi_c;
    lamp_t            in_lamp_c;
    logic             flash_on;

    tlc_flash_gen #(
        .FLASH_HALF (FLASH_HALF),
        .CNT_W      (CNT_W)
    ) u_flash (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (state == FAULT),
        .restart  (enter_c),
        .flash_on (flash_on)
    );

    // Classify the sampled request pattern.
    always_comb begin
        multi_c   = (r & g) | (r & y) | (g & y);
        in_lamp_c = NONE;
        if (r) begin
            in_lamp_c = RED;
        end else if (y) begin
            in_lamp_c = YELLOW;
        end else if (g) begin
            in_lamp_c = GREEN;
        end
    end

    // Next state and next registered outputs; fault checks ordered multi > seq > dark.
    always_comb begin
        state_nxt    = state;
        last_nxt     = last_lamp;
        dark_nxt     = dark_cnt;
        lamp_r_nxt   = 1'b0;
        lamp_g_nxt   = 1'b0;
        lamp_y_nxt   = 1'b0;
        fault_nxt    = 1'b0;
        code_nxt     = FC_NONE;
        enter_c      = 1'b0;
        enter_code_c = FC_NONE;

        case (state)
            IDLE: begin
                if (multi_c) begin
                    enter_c      = 1'b1;
                    enter_code_c = FC_MULTI;
                end else if (in_lamp_c == RED) begin
                    state_nxt  = RUN;
                    last_nxt   = RED;
                    dark_nxt   = '0;
                    lamp_r_nxt = 1'b1;
                end else if (in_lamp_c != NONE) begin
                    enter_c      = 1'b1;
                    enter_code_c = FC_SEQ;
                end
            end
            RUN: begin
                if (multi_c) begin
                    enter_c      = 1'b1;
                    enter_code_c = FC_MULTI;
                end else if (in_lamp_c != NONE) begin
                    if (in_lamp_c == last_lamp || in_lamp_c == lamp_succ(last_lamp)) begin
                        last_nxt   = in_lamp_c;
                        dark_nxt   = '0;
                        lamp_r_nxt = r;
                        lamp_g_nxt = g;
                        lamp_y_nxt = y;
                    end else begin
                        enter_c      = 1'b1;
                        enter_code_c = FC_SEQ;
                    end
                end else if (dark_cnt >= CNT_W'(DARK_MAX - 1)) begin
                    enter_c      = 1'b1;
                    enter_code_c = FC_DARK;
                end else begin
                    dark_nxt = dark_cnt + CNT_W'(1);
                end
            end
            FAULT: begin
                if (fault_clr) begin
                    state_nxt = IDLE;
                    last_nxt  = NONE;
                    dark_nxt  = '0;
                end else begin
                    fault_nxt  = 1'b1;
                    code_nxt   = fault_code;
                    lamp_y_nxt = flash_on;
                end
            end
            default: begin
                enter_c      = 1'b1;
                enter_code_c = FC_SEQ;
            end
        endcase

        if (enter_c) begin
            state_nxt  = FAULT;
            dark_nxt   = '0;
            fault_nxt  = 1'b1;
            code_nxt   = enter_code_c;
            lamp_r_nxt = 1'b0;
            lamp_g_nxt = 1'b0;
            lamp_y_nxt = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_lamp  <= NONE;
            dark_cnt   <= '0;
            lamp_r     <= 1'b0;
            lamp_g     <= 1'b0;
            lamp_y     <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
        end else begin
            state      <= state_nxt;
            last_lamp  <= last_nxt;
            dark_cnt   <= dark_nxt;
            lamp_r     <= lamp_r_nxt;
            lamp_g     <= lamp_g_nxt;
            lamp_y     <= lamp_y_nxt;
            fault      <= fault_nxt;
            fault_code <= code_nxt;
        end
    end

endmodule
